// File: rtl/soma_serial_nbit.sv
// soma_serial_nbit: bit-serial adder/subtractor. One full-adder cell and a
// carry flop process a WIDTH-bit operation LSB first, one bit per clock, with
// a start/done handshake toward the controlling FSM.
module soma_serial_nbit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state, state_next;

    // Operand shift registers, running carry, partial result and bit counter.
    // The partial result keeps only WIDTH-1 bits; the MSB of the final sum is
    // the bit produced on the last BUSY cycle.
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             c;
    logic [WIDTH-2:0] res;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             last_bit;
    logic             bit_s;
    logic             bit_c;
    logic [WIDTH-1:0] res_next;

    // Full-adder cell on the current LSBs and the partial result after this bit.
    always_comb begin
        bit_s    = op_a[0] ^ op_b[0] ^ c;
        bit_c    = (op_a[0] & op_b[0]) | (op_a[0] & c) | (op_b[0] & c);
        res_next = {bit_s, res};
        last_bit = (cnt == LAST_BIT);
    end

    // Next-state and handshake decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand load, serial bit processing and result capture on the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a     <= '0;
            op_b     <= '0;
            c        <= 1'b0;
            res      <= '0;
            cnt      <= '0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            op_a <= a;
            op_b <= sub ? ~b : b;
            c    <= sub ? 1'b1 : cin;
            res  <= '0;
            cnt  <= '0;
        end else if (state == BUSY) begin
            op_a <= op_a >> 1;
            op_b <= op_b >> 1;
            c    <= bit_c;
            res  <= res_next[WIDTH-1:1];
            cnt  <= cnt + 1'b1;
            if (last_bit) begin
                sum      <= res_next;
                carry    <= bit_c;
                overflow <= c ^ bit_c;
            end
        end
    end

endmodule
